// File: rtl/usb_serial_echo_buf_pkg.sv
// Shared constants for the USB serial byte-stream stage and its FIFO.
package usb_serial_echo_buf_pkg;

  localparam logic MODE_LOOPBACK = 1'b0;
  localparam logic MODE_PATTERN  = 1'b1;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // Saturating increment for the dropped-byte counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a
// synchronous clear. Push/pop requests are qualified internally, so a push
// into a full FIFO is only accepted when a pop frees the slot in the same cycle.
module usb_sync_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign do_pop  = pop & ~clear & ~empty;
  assign do_push = push & ~clear & (~full | do_pop);

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

  // Pointer update; both wrap modulo 2**(DEPTH_LOG2+1).
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/usb_serial_echo_buf.sv
// Application-side byte stage: echoes received bytes through a FIFO in
// LOOPBACK mode, or sources an incrementing byte stream in PATTERN mode.
// Handshake: a byte moves when send_valid & send_ready are both high at a
// posedge; send_valid/send_data come from registered state only and hold
// steady while send_ready is low. recv_valid is a strobe with no backpressure.
module usb_serial_echo_buf
  import usb_serial_echo_buf_pkg::*;
#(
  parameter int         DEPTH_LOG2    = 6,
  parameter logic [7:0] PATTERN_START = 8'h00
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  usb_rstn,
  input  logic                  mode,
  input  logic [7:0]            recv_data,
  input  logic                  recv_valid,
  output logic [7:0]            send_data,
  output logic                  send_valid,
  input  logic                  send_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  clear_stats
);

  logic       mode_q;
  logic       flush;
  logic       loopback;
  logic       fire;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_clear;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       drop;
  logic [7:0] pat_cnt;
  logic       pat_valid;

  // A bus reset or any mode change empties the stage and restarts the pattern.
  assign flush      = ~usb_rstn | (mode != mode_q);
  assign loopback   = (mode_q == MODE_LOOPBACK);
  assign fire       = send_valid & send_ready;
  assign fifo_pop   = loopback & fire & ~flush;
  assign fifo_push  = loopback & recv_valid & ~flush;
  assign fifo_clear = flush | ~loopback;
  assign drop       = loopback & recv_valid & ~flush & fifo_full & ~fifo_pop;

  usb_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (recv_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Empty FIFO presents 0 so send_data is defined after reset.
  assign send_valid = loopback ? ~fifo_empty : pat_valid;
  assign send_data  = loopback ? (fifo_empty ? 8'h00 : fifo_rdata) : pat_cnt;

  // Registered copy of mode used to detect mode changes.
  always_ff @(posedge clk) begin
    if (!rstn) mode_q <= MODE_LOOPBACK;
    else       mode_q <= mode;
  end

  // Pattern source: valid rises one cycle after a clean, non-flushing cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat_cnt   <= PATTERN_START;
      pat_valid <= 1'b0;
    end else begin
      pat_valid <= usb_rstn & ~flush & (mode_q == MODE_PATTERN);
      if (flush)                pat_cnt <= PATTERN_START;
      else if (!loopback && fire) pat_cnt <= pat_cnt + 1'b1;
    end
  end

  // Drop statistics; clear_stats wins over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (!rstn || clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_usb_serial_echo_buf.sv
// Directed bench for usb_serial_echo_buf (depth 4, pattern start 8'hFE) with
// a queue-based reference model checked every cycle.
module tb_usb_serial_echo_buf;

  localparam int         DL2    = 2;
  localparam int         DEPTH  = 1 << DL2;
  localparam logic [7:0] PSTART = 8'hFE;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        usb_rstn = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  recv_data = 8'h00;
  logic        recv_valid = 1'b0;
  logic [7:0]  send_data;
  logic        send_valid;
  logic        send_ready = 1'b0;
  logic [DL2:0] level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_stats = 1'b0;

  always #5 clk = ~clk;

  usb_serial_echo_buf #(
    .DEPTH_LOG2    (DL2),
    .PATTERN_START (PSTART)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .usb_rstn    (usb_rstn),
    .mode        (mode),
    .recv_data   (recv_data),
    .recv_valid  (recv_valid),
    .send_data   (send_data),
    .send_valid  (send_valid),
    .send_ready  (send_ready),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clear_stats (clear_stats)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  bit          m_live = 0;
  logic        m_mode_q;
  logic [7:0]  m_pat;
  logic        m_pvalid;
  logic        m_ovf;
  logic [15:0] m_drops;
  bit          mv_valid, mv_fire, mv_flush, mv_drop;

  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      m_mode_q = 1'b0;
      m_pat    = PSTART;
      m_pvalid = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 16'h0000;
      m_live   = 1;
    end else if (m_live) begin
      mv_valid = m_mode_q ? m_pvalid : (exp_q.size() != 0);
      mv_fire  = mv_valid && send_ready;
      mv_flush = !usb_rstn || (mode != m_mode_q);
      mv_drop  = 0;
      if (mv_flush) begin
        exp_q.delete();
        m_pat = PSTART;
      end else if (!m_mode_q) begin
        if (mv_fire) void'(exp_q.pop_front());
        if (recv_valid) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(recv_data);
          else mv_drop = 1;
        end
      end else begin
        if (mv_fire) m_pat = m_pat + 8'h01;
      end
      m_pvalid = usb_rstn && !mv_flush && m_mode_q;
      if (clear_stats) begin
        m_ovf   = 1'b0;
        m_drops = 16'h0000;
      end else if (mv_drop) begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'h0001;
      end
      m_mode_q = mode;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0] sent_log[$];
  bit         ce_valid;

  always @(negedge clk) begin
    if (m_live) begin
      ce_valid = m_mode_q ? m_pvalid : (exp_q.size() != 0);
      check("send_valid", {31'd0, send_valid}, {31'd0, ce_valid});
      if (ce_valid)
        check("send_data", {24'd0, send_data}, {24'd0, (m_mode_q ? m_pat : exp_q[0])});
      check("level", {29'd0, level}, exp_q.size());
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("drop_count", {16'd0, drop_count}, {16'd0, m_drops});
      if (rstn && usb_rstn && (mode == m_mode_q) && send_valid && send_ready)
        sent_log.push_back(send_data);
    end
  end

  function automatic logic [31:0] log_at(input int i);
    return (i < sent_log.size()) ? {24'd0, sent_log[i]} : 32'hDEAD;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0; usb_rstn = 1'b1; mode = 1'b0; recv_valid = 1'b0;
    recv_data = 8'h00; send_ready = 1'b0; clear_stats = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic recv(input logic [7:0] b);
    recv_valid = 1'b1;
    recv_data  = b;
    tick();
    recv_valid = 1'b0;
  endtask

  logic [7:0] t1_exp [3] = '{8'h41, 8'h42, 8'h43};
  logic [7:0] t2_exp [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hAA};
  logic [7:0] t4_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();
    check("rst_send_valid", {31'd0, send_valid}, 32'd0);
    check("rst_send_data", {24'd0, send_data}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);

    // 1: loopback echo and one-cycle latency
    send_ready = 1'b1;
    sent_log.delete();
    recv_valid = 1'b1; recv_data = 8'h41;
    tick();
    check("t1_latency_valid", {31'd0, send_valid}, 32'd1);
    check("t1_latency_data", {24'd0, send_data}, 32'h41);
    recv_data = 8'h42; tick();
    recv_data = 8'h43; tick();
    recv_valid = 1'b0;
    tick(3);
    check("t1_count", sent_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) check("t1_byte", log_at(i), {24'd0, t1_exp[i]});

    // 2: overflow with send_ready low
    send_ready = 1'b0;
    for (int i = 0; i < 6; i++) recv(i[7:0]);
    check("t2_level", {29'd0, level}, 32'd4);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_drops", {16'd0, drop_count}, 32'd2);

    // 3: push and pop together while full
    sent_log.delete();
    send_ready = 1'b1;
    recv(8'hAA);
    check("t3_level", {29'd0, level}, 32'd4);
    check("t3_drops", {16'd0, drop_count}, 32'd2);
    tick(4);
    check("t2_count", sent_log.size(), 32'd5);
    for (int i = 0; i < 5; i++) check("t2_byte", log_at(i), {24'd0, t2_exp[i]});
    check("t2_drained", {29'd0, level}, 32'd0);

    // 4: pattern stream with stalls, wrapping FF -> 00
    apply_reset();
    mode = 1'b1;
    send_ready = 1'b0;
    tick();
    sent_log.delete();
    for (int i = 0; i < 12; i++) begin
      send_ready = (i % 2 == 0);
      recv_valid = (i % 3 == 0);
      recv_data  = 8'h77;
      tick();
    end
    recv_valid = 1'b0;
    send_ready = 1'b0;
    for (int i = 0; i < 4; i++) check("t4_byte", log_at(i), {24'd0, t4_exp[i]});
    check("t4_level", {29'd0, level}, 32'd0);

    // 5: usb reset flushes loopback content and ignores recv
    mode = 1'b0;
    tick();
    recv(8'h11); recv(8'h22); recv(8'h33);
    check("t5_level", {29'd0, level}, 32'd3);
    usb_rstn = 1'b0;
    recv(8'h44);
    usb_rstn = 1'b1;
    check("t5_flush_level", {29'd0, level}, 32'd0);
    check("t5_flush_valid", {31'd0, send_valid}, 32'd0);
    check("t5_no_drop", {16'd0, drop_count}, 32'd0);
    tick();
    check("t5_after_level", {29'd0, level}, 32'd0);

    // 6: saturation, clear priority, reset mid-stream
    apply_reset();
    recv_valid = 1'b1;
    recv_data  = 8'h5A;
    tick(DEPTH + 65535 + 3);
    check("t6_saturated", {16'd0, drop_count}, 32'hFFFF);
    check("t6_overflow", {31'd0, overflow}, 32'd1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t6_clear_ovf", {31'd0, overflow}, 32'd0);
    check("t6_clear_cnt", {16'd0, drop_count}, 32'd0);
    tick(2);
    check("t6_recount", {16'd0, drop_count}, 32'd2);
    send_ready = 1'b1;
    tick(2);
    rstn = 1'b0;
    tick();
    check("t6_rst_valid", {31'd0, send_valid}, 32'd0);
    check("t6_rst_data", {24'd0, send_data}, 32'd0);
    check("t6_rst_level", {29'd0, level}, 32'd0);
    check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    check("t6_rst_cnt", {16'd0, drop_count}, 32'd0);
    rstn = 1'b1;
    recv_valid = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
